fm_read_seq: RTL and testbench

Read sequencer placed directly upstream of the flash SPI byte engine. It takes a read request (24-bit address, byte count), issues READ 0x03 plus 3 address bytes, clocks out dummy 0xFF bytes, and streams the returned bytes to the consumer. It owns chip-select setup and deselect timing. The SPI engine loads its transmit byte only while its enable is low, so the sequencer drops the enable for one cycle before every byte.

---
 rtl/fm_pkg.sv | 28 ++
 rtl/fm_read_seq_if.sv | 35 +++
 rtl/fm_gap_timer.sv | 25 ++
 rtl/fm_read_seq.sv | 138 +++++++++++++
 tb/tb_fm_read_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fm_pkg.sv
// Shared types and constants for the flash read sequencer.
// FM_FAST_READ_EN selects FAST READ (0x0B plus one dummy byte).
package fm_pkg;

    typedef logic [2:0] fm_state_t;

    localparam fm_state_t ST_IDLE  = 3'd0;
    localparam fm_state_t ST_SETUP = 3'd1;
    localparam fm_state_t ST_LOAD  = 3'd2;
    localparam fm_state_t ST_SHIFT = 3'd3;
    localparam fm_state_t ST_DESEL = 3'd4;

    localparam logic [7:0] FM_CMD_READ      = 8'h03;
    localparam logic [7:0] FM_CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] FM_DUMMY         = 8'hFF;

    localparam int FM_HDR_LEN_READ = 4;
    localparam int FM_HDR_LEN_FAST = 5;

`ifdef FM_FAST_READ_EN
    localparam logic [7:0] FM_CMD     = FM_CMD_FAST_READ;
    localparam int         FM_HDR_LEN = FM_HDR_LEN_FAST;
`else
    localparam logic [7:0] FM_CMD     = FM_CMD_READ;
    localparam int         FM_HDR_LEN = FM_HDR_LEN_READ;
`endif

endpackage

// File: rtl/fm_read_seq_if.sv
// Request/stream/SPI-engine bundle of the flash read sequencer.
// slave is the sequencer's view, master the surrounding logic's view.
interface fm_read_seq_if #(
    parameter int pAddrW = 24,
    parameter int pLenW  = 16
);
    logic              iReq;
    logic [pAddrW-1:0] iAddr;
    logic [pLenW-1:0]  iLen;
    logic              iAbort;
    logic              oBusy;
    logic              oDone;
    logic [7:0]        oRd;
    logic              oRdVd;
    logic              oSpiCs;
    logic              oSpiCke;
    logic [7:0]        oSpiWd;
    logic              iSpiWdVd;
    logic              iSpiRdVd;
    logic [7:0]        iSpiRd;

    modport slave (
        input  iReq, iAddr, iLen, iAbort,
        input  iSpiWdVd, iSpiRdVd, iSpiRd,
        output oBusy, oDone, oRd, oRdVd,
        output oSpiCs, oSpiCke, oSpiWd
    );

    modport master (
        output iReq, iAddr, iLen, iAbort,
        output iSpiWdVd, iSpiRdVd, iSpiRd,
        input  oBusy, oDone, oRd, oRdVd,
        input  oSpiCs, oSpiCke, oSpiWd
    );
endinterface

// File: rtl/fm_gap_timer.sv
// Loadable down-counter timing the CS setup and deselect gaps.
// zero is high once the loaded count has run out.
module fm_gap_timer #(
    parameter int pW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [pW-1:0] value,
    output logic          zero
);
    logic [pW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/fm_read_seq.sv
// Flash read sequencer: READ header, dummy clocking, data streaming.
// FM_FAST_READ_EN (in fm_pkg) switches to the FAST READ header.
module fm_read_seq
    import fm_pkg::*;
#(
    parameter int pAddrW   = 24,
    parameter int pLenW    = 16,
    parameter int pCsSetup = 2,
    parameter int pCsDesel = 10
) (
    input logic          iSysClk,
    input logic          iSysRst,
    fm_read_seq_if.slave bus
);
    localparam int TMAX = (pCsSetup > pCsDesel) ? pCsSetup : pCsDesel;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [pLenW:0] HDR      = (pLenW+1)'(FM_HDR_LEN);
    localparam logic [pLenW:0] LAST_HDR = (pLenW+1)'(FM_HDR_LEN - 1);

    fm_state_t         state;
    logic [pLenW:0]    idx;
    logic [pLenW:0]    last_idx;
    logic [pAddrW-1:0] addr;
    logic              busy, done, rd_vd, cs, cke;
    logic [7:0]        rd, wd;

    logic          active, accept, abort, sent, to_desel, data;
    logic          tmr_load, tmr_zero;
    logic [TW-1:0] tmr_val;

    function automatic logic [7:0] seq_byte(
        input logic [pLenW:0]    i,
        input logic [pAddrW-1:0] a
    );
        logic [7:0] b;
        b = FM_DUMMY;
        if (i[pLenW:2] == '0) begin
            case (i[1:0])
                2'd0:    b = FM_CMD;
                2'd1:    b = a[23:16];
                2'd2:    b = a[15:8];
                default: b = a[7:0];
            endcase
        end
        return b;
    endfunction

    assign active   = (state == ST_SETUP) || (state == ST_LOAD)
                   || (state == ST_SHIFT);
    assign accept   = (state == ST_IDLE) && bus.iReq && !done;
    assign abort    = active && bus.iAbort;
    assign sent     = (state == ST_SHIFT) && bus.iSpiWdVd;
    assign to_desel = abort || (sent && (idx == last_idx));
    // A byte completing alongside an abort is still delivered
    assign data     = (state == ST_SHIFT) && bus.iSpiRdVd && (idx >= HDR);
    assign tmr_load = accept || to_desel;
    assign tmr_val  = accept ? TW'(pCsSetup - 1) : TW'(pCsDesel - 1);

    fm_gap_timer #(.pW(TW)) u_gap (
        .clk   (iSysClk),
        .rst_n (iSysRst),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            last_idx <= '0;
            addr     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd       <= 8'h00;
            rd_vd    <= 1'b0;
            cs       <= 1'b1;
            cke      <= 1'b0;
            wd       <= FM_DUMMY;
        end else begin
            done  <= 1'b0;
            rd_vd <= 1'b0;
            if (data) begin
                rd    <= bus.iSpiRd;
                rd_vd <= 1'b1;
            end
            unique case (1'b1)
                state == ST_IDLE: begin
                    if (accept) begin
                        addr     <= bus.iAddr;
                        last_idx <= {1'b0, bus.iLen} + LAST_HDR;
                        idx      <= '0;
                        busy     <= 1'b1;
                        cs       <= 1'b0;
                        state    <= ST_SETUP;
                    end
                end
                state == ST_SETUP, state == ST_LOAD, state == ST_SHIFT: begin
                    if (to_desel) begin
                        cs    <= 1'b1;
                        cke   <= 1'b0;
                        wd    <= FM_DUMMY;
                        state <= ST_DESEL;
                    end else if (state == ST_SETUP) begin
                        if (tmr_zero) begin
                            wd    <= seq_byte(idx, addr);
                            state <= ST_LOAD;
                        end
                    end else if (state == ST_LOAD) begin
                        cke   <= 1'b1;
                        state <= ST_SHIFT;
                    end else if (sent) begin
                        idx   <= idx + 1'b1;
                        wd    <= seq_byte(idx + 1'b1, addr);
                        cke   <= 1'b0;
                        state <= ST_LOAD;
                    end
                end
                state == ST_DESEL: begin
                    if (tmr_zero) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.oBusy   = busy;
    assign bus.oDone   = done;
    assign bus.oRd     = rd;
    assign bus.oRdVd   = rd_vd;
    assign bus.oSpiCs  = cs;
    assign bus.oSpiCke = cke;
    assign bus.oSpiWd  = wd;
endmodule

// File: tb/tb_fm_read_seq.sv
// Bench for fm_read_seq: SPI engine/flash model plus per-cycle checker.
// Build with FM_FAST_READ_EN defined to exercise the FAST READ header.
module tb_fm_read_seq;
`ifdef FM_FAST_READ_EN
    localparam int         H   = 5;
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam int         H   = 4;
    localparam logic [7:0] CMD = 8'h03;
`endif
    localparam int DESEL = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fm_read_seq_if #(.pAddrW(24), .pLenW(16)) bus ();

    fm_read_seq #(
        .pAddrW(24), .pLenW(16), .pCsSetup(2), .pCsDesel(DESEL)
    ) dut (
        .iSysClk (clk),
        .iSysRst (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [7:0] resp_q[$];
    logic [7:0] wire_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] rd_log[$];
    logic [7:0] r_byte;

    int   pos = 0, cnt = 0;
    bit   armed = 1'b1, rd_pending = 1'b0;
    int   abort_pos = -1;
    bit   abort_on_pulse = 1'b0;
    int   bursts = 0, done_cnt = 0, rdvd_cnt = 0, accepts = 0;
    int   cs_low_run = 0, desel_run = 0, cyc = 0, done_cyc = -100;
    bit   gap_check = 1'b0;
    logic cke_prev = 1'b0, busy_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] model_byte(input int i,
                                              input logic [23:0] a);
        if (i == 0) return CMD;
        if (i == 1) return a[23:16];
        if (i == 2) return a[15:8];
        if (i == 3) return a[7:0];
        return 8'hFF;
    endfunction

    // Engine model, flash responses and per-cycle output checks
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rd_pending = 1'b0;
            exp_rd_q.delete();
            pos = 0; cnt = 0; armed = 1'b1;
            cs_low_run = 0; desel_run = 0;
            cke_prev = 1'b0; busy_prev = 1'b0;
            bus.iSpiWdVd = 1'b0; bus.iSpiRdVd = 1'b0;
            bus.iSpiRd = 8'h00; bus.iAbort = 1'b0;
        end else begin
            chk("rdvd_timing", bus.oRdVd, rd_pending);
            if (bus.oRdVd) begin
                rdvd_cnt++;
                rd_log.push_back(bus.oRd);
                if (exp_rd_q.size() > 0)
                    chk("rd_data", bus.oRd, exp_rd_q.pop_front());
            end
            rd_pending = 1'b0;
            if (bus.oSpiCke) chk("cs_low_while_en", bus.oSpiCs, 0);
            cs_low_run = bus.oSpiCs ? 0 : cs_low_run + 1;
            if (bus.oSpiCke && !cke_prev) begin
                bursts++;
                if (pos == 0) chk("cs_setup_ge2", (cs_low_run - 1) >= 2, 1);
            end
            if (bus.oBusy && bus.oSpiCs) desel_run++;
            if (bus.oDone) begin
                done_cnt++;
                done_cyc = cyc;
                chk("desel_cycles", desel_run, DESEL);
                chk("cs_high_at_done", bus.oSpiCs, 1);
                desel_run = 0;
            end
            if (bus.oBusy && !busy_prev) begin
                accepts++;
                if (gap_check) chk("reaccept_gap", cyc - done_cyc, 2);
            end
            cke_prev  = bus.oSpiCke;
            busy_prev = bus.oBusy;

            bus.iSpiWdVd = 1'b0;
            bus.iSpiRdVd = 1'b0;
            bus.iAbort   = 1'b0;
            if (!bus.oBusy) pos = 0;
            if (bus.oSpiCs || !bus.oSpiCke) begin
                cnt = 0;
                armed = 1'b1;
            end else if (armed) begin
                cnt++;
                if (cnt == 1 && pos == abort_pos && !abort_on_pulse) begin
                    bus.iAbort = 1'b1;
                    abort_pos = -1;
                end
                if (cnt == 3) begin
                    if (resp_q.size() > 0) r_byte = resp_q.pop_front();
                    else r_byte = 8'h00;
                    bus.iSpiWdVd = 1'b1;
                    bus.iSpiRdVd = 1'b1;
                    bus.iSpiRd   = r_byte;
                    wire_q.push_back(bus.oSpiWd);
                    if (pos >= H) begin
                        exp_rd_q.push_back(r_byte);
                        rd_pending = 1'b1;
                    end
                    if (pos == abort_pos && abort_on_pulse) begin
                        bus.iAbort = 1'b1;
                        abort_pos = -1;
                    end
                    pos++;
                    armed = 1'b0;
                end
            end
        end
    end

    task automatic prep();
        wire_q.delete();
        rd_log.delete();
        resp_q.delete();
        repeat (H) resp_q.push_back(8'h5A);
    endtask

    task automatic start(input logic [23:0] a, input logic [15:0] l);
        @(negedge clk);
        bus.iReq  = 1'b1;
        bus.iAddr = a;
        bus.iLen  = l;
        @(negedge clk);
        bus.iReq  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.oDone) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_wire(input logic [23:0] a, input int n);
        chk("wire_count", wire_q.size(), n);
        foreach (wire_q[i])
            chk($sformatf("wire_byte%0d", i), wire_q[i], model_byte(i, a));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, b0, a0;
        bit got;
        bus.iReq  = 1'b0;
        bus.iAddr = '0;
        bus.iLen  = '0;
        #12;
        chk("rst_cs", bus.oSpiCs, 1);
        chk("rst_cke", bus.oSpiCke, 0);
        chk("rst_wd", bus.oSpiWd, 8'hFF);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_done", bus.oDone, 0);
        chk("rst_rd", bus.oRd, 0);
        chk("rst_rdvd", bus.oRdVd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic read of three bytes
        prep();
        resp_q.push_back(8'hA1);
        resp_q.push_back(8'hB2);
        resp_q.push_back(8'hC3);
        d0 = done_cnt; r0 = rdvd_cnt;
        start(24'h123456, 16'd3);
        wait_done(400);
        chk_wire(24'h123456, H + 3);
        chk("t1_op", wire_q[0], CMD);
        chk("t1_a2", wire_q[1], 8'h12);
        chk("t1_a1", wire_q[2], 8'h34);
        chk("t1_a0", wire_q[3], 8'h56);
        chk("t1_last_ff", wire_q[H + 2], 8'hFF);
        chk("t1_rdvd_n", rdvd_cnt - r0, 3);
        if (rd_log.size() == 3) begin
            chk("t1_rd0", rd_log[0], 8'hA1);
            chk("t1_rd1", rd_log[1], 8'hB2);
            chk("t1_rd2", rd_log[2], 8'hC3);
        end
        chk("t1_done_n", done_cnt - d0, 1);

        // Header only
        prep();
        d0 = done_cnt; r0 = rdvd_cnt; b0 = bursts;
        start(24'hABCDEF, 16'd0);
        wait_done(400);
        chk("t2_bursts", bursts - b0, H);
        chk("t2_rdvd_n", rdvd_cnt - r0, 0);
        chk("t2_done_n", done_cnt - d0, 1);
        chk_wire(24'hABCDEF, H);

        // Abort while the second data byte is shifting
        prep();
        resp_q.push_back(8'h11);
        resp_q.push_back(8'h22);
        resp_q.push_back(8'h33);
        resp_q.push_back(8'h44);
        abort_pos = H + 1;
        d0 = done_cnt; r0 = rdvd_cnt;
        start(24'h000100, 16'd4);
        wait_done(400);
        chk("t3_rdvd_n", rdvd_cnt - r0, 1);
        if (rd_log.size() == 1) chk("t3_rd0", rd_log[0], 8'h11);
        chk("t3_done_n", done_cnt - d0, 1);
        chk("t3_cs_high", bus.oSpiCs, 1);
        chk("t3_wire_n", wire_q.size(), H + 1);

        // Abort coincident with the last data byte completing
        prep();
        resp_q.push_back(8'h77);
        resp_q.push_back(8'h88);
        abort_pos = H + 1;
        abort_on_pulse = 1'b1;
        d0 = done_cnt; r0 = rdvd_cnt;
        start(24'h00ABCD, 16'd2);
        wait_done(400);
        abort_on_pulse = 1'b0;
        abort_pos = -1;
        chk("t4_rdvd_n", rdvd_cnt - r0, 2);
        if (rd_log.size() == 2) chk("t4_rd1", rd_log[1], 8'h88);
        chk("t4_done_n", done_cnt - d0, 1);
        chk_wire(24'h00ABCD, H + 2);

        // Asynchronous reset in the middle of the data phase
        prep();
        for (int i = 0; i < 8; i++) resp_q.push_back(8'(8'h30 + i));
        start(24'h0F0F0F, 16'd8);
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (pos >= H + 2 && bus.oSpiCke) begin
                got = 1'b1;
                break;
            end
        end
        chk("t5_reached_shift", got, 1);
        d0 = done_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_cs", bus.oSpiCs, 1);
        chk("t5_async_cke", bus.oSpiCke, 0);
        chk("t5_async_busy", bus.oBusy, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 0);
        prep();
        resp_q.push_back(8'hC4);
        resp_q.push_back(8'hD5);
        d0 = done_cnt; r0 = rdvd_cnt;
        start(24'hABCDEF, 16'd2);
        wait_done(400);
        chk("t5_rdvd_n", rdvd_cnt - r0, 2);
        if (rd_log.size() == 2) chk("t5_rd1", rd_log[1], 8'hD5);
        chk("t5_done_n", done_cnt - d0, 1);
        chk_wire(24'hABCDEF, H + 2);

        // Request held high across two transfers
        prep();
        for (int i = 0; i < 8; i++) resp_q.push_back(8'(8'h60 + i));
        d0 = done_cnt; a0 = accepts;
        @(negedge clk);
        bus.iReq  = 1'b1;
        bus.iAddr = 24'h000010;
        bus.iLen  = 16'd1;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.oDone) begin
                gap_check = 1'b1;
                got = 1'b1;
                break;
            end
        end
        chk("t6_first_done", got, 1);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.oDone) begin
                bus.iReq = 1'b0;
                got = 1'b1;
                break;
            end
        end
        bus.iReq = 1'b0;
        chk("t6_second_done", got, 1);
        repeat (5) @(negedge clk);
        gap_check = 1'b0;
        chk("t6_accepts", accepts - a0, 2);
        chk("t6_done_n", done_cnt - d0, 2);

        // Zero address, single data byte
        prep();
        resp_q.push_back(8'hE7);
        r0 = rdvd_cnt;
        start(24'h000000, 16'd1);
        wait_done(400);
        chk_wire(24'h000000, H + 1);
        chk("t7_rdvd_n", rdvd_cnt - r0, 1);
        if (rd_log.size() == 1) chk("t7_rd", rd_log[0], 8'hE7);
`ifdef FM_FAST_READ_EN
        chk("t7_op", wire_q[0], 8'h0B);
        chk("t7_dummy", wire_q[4], 8'hFF);
        chk("t7_data", wire_q[5], 8'hFF);
`else
        chk("t7_op", wire_q[0], 8'h03);
        chk("t7_data", wire_q[4], 8'hFF);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
